// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: bundles the sequencer handshake, sprite ROM port and
// vga_adapter pixel stream of sprite_blitter.
//   slave  : the blitter (takes start/origin/size/base and rom_q, drives
//            rom_addr, x/y/colour/plot, busy, done)
//   master : the surrounding sequencer / ROM / frame-buffer side
interface sprite_blitter_if #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int ADDR_W   = 14,
  parameter int COLOUR_W = 3,
  parameter int DIM_W    = 8
);
  logic                start;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [DIM_W-1:0]    width;
  logic [DIM_W-1:0]    height;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_q;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  modport slave (
    input  start, x0, y0, width, height, base_addr, rom_q,
    output rom_addr, x, y, colour, plot, busy, done
  );

  modport master (
    output start, x0, y0, width, height, base_addr, rom_q,
    input  rom_addr, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a width x height sprite from a synchronous colour
// ROM into the frame buffer at a runtime origin, one pixel per clock.
// The ROM address stream is row-major; screen coordinates and the on-screen
// flag travel down a ROM_LATENCY-deep delay line so they meet rom_q, and a
// final register stage drives x/y/colour/plot. Off-screen pixels still take
// their cycle (plot=0), so draw time depends only on width*height.
//
// Ports:
//   clk, reset (async, active-high)
//   bus (sprite_blitter_if.slave): start/x0/y0/width/height/base_addr in,
//     rom_addr out / rom_q in, x/y/colour/plot out, busy/done out
//
// Optional build macro SPRITE_BLITTER_TRANSPARENCY_EN: pixels whose ROM
// colour equals TRANSPARENT_COLOUR are not plotted.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; parameters latched on acceptance
// S_SCAN  | issuing one ROM address per cycle
// S_DRAIN | ROM_LATENCY+1 cycles flushing the read/output pipeline
// S_DONE  | one-cycle done pulse
module sprite_blitter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int ADDR_W   = 14,
  parameter int COLOUR_W = 3,
  parameter int DIM_W    = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ROM_LATENCY = 1,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = '0
) (
  input logic clk,
  input logic reset,
  sprite_blitter_if.slave bus
);

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam int DRN_W = $clog2(ROM_LATENCY + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [DIM_W-1:0]    w_q, h_q, col, row;
  logic [DRN_W-1:0]    drain_cnt;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                plot_q;

  logic                col_last, last_px;
  logic [X_W:0]        sx;
  logic [Y_W:0]        sy;
  logic                in_bounds, key_hit, px_go;

  logic                v_d  [ROM_LATENCY];
  logic                in_d [ROM_LATENCY];
  logic [X_W-1:0]      sx_d [ROM_LATENCY];
  logic [Y_W-1:0]      sy_d [ROM_LATENCY];

  assign col_last = (col == w_q - DIM_W'(1));
  assign last_px  = col_last && (row == h_q - DIM_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start)
                 state_nx = (bus.width != '0 && bus.height != '0) ? S_SCAN : S_DONE;
      S_SCAN:  if (last_px) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Rows are contiguous in the ROM, so base + row*W + col is just a
  // running increment from base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col        <= '0;
      row        <= '0;
      drain_cnt  <= '0;
      rom_addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          x0_q       <= bus.x0;
          y0_q       <= bus.y0;
          w_q        <= bus.width;
          h_q        <= bus.height;
          col        <= '0;
          row        <= '0;
          rom_addr_q <= bus.base_addr;
        end
        S_SCAN: begin
          rom_addr_q <= rom_addr_q + ADDR_W'(1);
          if (col_last) begin
            col <= '0;
            row <= row + DIM_W'(1);
          end else begin
            col <= col + DIM_W'(1);
          end
          if (last_px) drain_cnt <= DRN_W'(ROM_LATENCY);
        end
        S_DRAIN: drain_cnt <= drain_cnt - DRN_W'(1);
        default: ;
      endcase
    end
  end

  // One extra bit so origin + offset cannot wrap back on-screen.
  assign sx        = (X_W+1)'(x0_q) + (X_W+1)'(col);
  assign sy        = (Y_W+1)'(y0_q) + (Y_W+1)'(row);
  assign in_bounds = (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        v_d[i]  <= 1'b0;
        in_d[i] <= 1'b0;
        sx_d[i] <= '0;
        sy_d[i] <= '0;
      end
    end else begin
      v_d[0]  <= (state == S_SCAN);
      in_d[0] <= in_bounds;
      sx_d[0] <= sx[X_W-1:0];
      sy_d[0] <= sy[Y_W-1:0];
      for (int i = 1; i < ROM_LATENCY; i++) begin
        v_d[i]  <= v_d[i-1];
        in_d[i] <= in_d[i-1];
        sx_d[i] <= sx_d[i-1];
        sy_d[i] <= sy_d[i-1];
      end
    end
  end

  assign key_hit = TRANSP_EN && (bus.rom_q == TRANSPARENT_COLOUR);
  assign px_go   = v_d[ROM_LATENCY-1] && in_d[ROM_LATENCY-1] && !key_hit;

  // x/y/colour only move when a pixel is actually plotted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      plot_q <= px_go;
      if (px_go) begin
        x_q      <= sx_d[ROM_LATENCY-1];
        y_q      <= sy_d[ROM_LATENCY-1];
        colour_q <= bus.rom_q;
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.busy     = (state == S_SCAN) || (state == S_DRAIN);
  assign bus.done     = (state == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: one instance at ROM_LATENCY=1 and one
// at ROM_LATENCY=3, each fed by a behavioural synchronous ROM.
module tb_sprite_blitter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  // expected held x/y/colour of dut1
  logic [8:0] ex;
  logic [7:0] ey;
  logic [2:0] ec;

  sprite_blitter_if #(.X_W(9), .Y_W(8), .ADDR_W(14), .COLOUR_W(3), .DIM_W(8)) bus1 ();
  sprite_blitter_if #(.X_W(9), .Y_W(8), .ADDR_W(14), .COLOUR_W(3), .DIM_W(8)) bus3 ();

  sprite_blitter #(.ROM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  sprite_blitter #(.ROM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // mode 0: colour = addr[2:0]; mode 1: 0 at odd addresses, 5 at even
  function automatic logic [2:0] romf(input logic [13:0] a);
    if (rom_mode == 1) return a[0] ? 3'd0 : 3'd5;
    return a[2:0];
  endfunction

  logic [2:0] rq1 = '0;
  logic [2:0] r3a = '0, r3b = '0, r3c = '0;
  always @(posedge clk) begin
    rq1 <= romf(bus1.rom_addr);
    r3a <= romf(bus3.rom_addr);
    r3b <= r3a;
    r3c <= r3b;
  end
  assign bus1.rom_q = rq1;
  assign bus3.rom_q = r3c;

  // Full draw on dut1 (L=1) with expected stream from a small model.
  task automatic run_draw(input int w, input int h, input int x0, input int y0,
                          input int base, input bit poke, input string tag);
    int n;
    n = w * h;
    bus1.x0 = 9'(x0); bus1.y0 = 8'(y0);
    bus1.width = 8'(w); bus1.height = 8'(h);
    bus1.base_addr = 14'(base);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int c = 1; c <= n + 4; c++) begin
      int k;
      logic [13:0] ea;
      logic [9:0] sx;
      logic [8:0] sy;
      logic [2:0] col;
      logic exp_plot, exp_busy, exp_done;
      if (c <= n) begin
        ea = 14'(base + c - 1);
        checks++;
        if (bus1.rom_addr !== ea) begin
          errors++;
          $display("FAIL %s rom_addr cyc %0d got %0d exp %0d", tag, c, bus1.rom_addr, ea);
        end
      end
      exp_plot = 1'b0;
      k = c - 3;
      if (k >= 0 && k < n) begin
        sx = 10'(x0 + k % w);
        sy = 9'(y0 + k / w);
        col = romf(14'(base + k));
        exp_plot = (sx < 10'd320) && (sy < 9'd240) && !(TR && col == 3'd0);
        if (exp_plot) begin ex = sx[8:0]; ey = sy[7:0]; ec = col; end
      end
      exp_busy = (c <= n + 2);
      exp_done = (c == n + 3);
      checks++;
      if (bus1.plot !== exp_plot) begin
        errors++;
        $display("FAIL %s plot cyc %0d got %0b exp %0b", tag, c, bus1.plot, exp_plot);
      end
      checks++;
      if ({bus1.x, bus1.y, bus1.colour} !== {ex, ey, ec}) begin
        errors++;
        $display("FAIL %s xyc cyc %0d got %0d,%0d,%0d exp %0d,%0d,%0d", tag, c,
                 bus1.x, bus1.y, bus1.colour, ex, ey, ec);
      end
      checks++;
      if ({bus1.busy, bus1.done} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL %s busy/done cyc %0d got %0b%0b exp %0b%0b", tag, c,
                 bus1.busy, bus1.done, exp_busy, exp_done);
      end
      if (poke && c == 4) begin bus1.start = 1'b1; bus1.x0 = 9'd50; end
      if (poke && c == 5) bus1.start = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus1.rom_addr, bus1.x, bus1.y, bus1.colour, bus1.plot, bus1.busy, bus1.done} !== '0) begin
      errors++;
      $display("FAIL reset dut1 got addr %0d x %0d y %0d c %0d p%0b b%0b d%0b exp all 0",
               bus1.rom_addr, bus1.x, bus1.y, bus1.colour, bus1.plot, bus1.busy, bus1.done);
    end
    checks++;
    if ({bus3.plot, bus3.busy, bus3.done} !== 3'b000) begin
      errors++;
      $display("FAIL reset dut3 got p%0b b%0b d%0b exp 000", bus3.plot, bus3.busy, bus3.done);
    end
    @(negedge clk) reset = 1'b0;
    ex = '0; ey = '0; ec = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    rom_mode = 0;
    run_draw(4, 2, 10, 20, 100, 1'b0, "basic");
  endtask

  task automatic test_zero();
    bus1.width = 8'd0; bus1.height = 8'd5; bus1.start = 1'b1;
    bus3.width = 8'd0; bus3.height = 8'd5; bus3.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0; bus3.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      logic exp_done;
      exp_done = (c == 1);
      checks++;
      if ({bus1.done, bus1.busy, bus1.plot} !== {exp_done, 2'b00}) begin
        errors++;
        $display("FAIL zero_l1 cyc %0d got d%0b b%0b p%0b exp d%0b b0 p0", c,
                 bus1.done, bus1.busy, bus1.plot, exp_done);
      end
      checks++;
      if ({bus3.done, bus3.busy, bus3.plot} !== {exp_done, 2'b00}) begin
        errors++;
        $display("FAIL zero_l3 cyc %0d got d%0b b%0b p%0b exp d%0b b0 p0", c,
                 bus3.done, bus3.busy, bus3.plot, exp_done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clip();
    rom_mode = 0;
    run_draw(4, 1, 318, 239, 0, 1'b0, "clip_x");
    run_draw(2, 2, 0, 239, 8, 1'b0, "clip_y");
  endtask

  task automatic test_transparency();
    rom_mode = 1;
    run_draw(4, 2, 0, 0, 100, 1'b0, "transp");
    rom_mode = 0;
  endtask

  task automatic test_ignore_start();
    run_draw(4, 2, 10, 20, 100, 1'b1, "restart");
  endtask

  // 2x2 at (5,6), base 8, L=3: colours 0..3, plot cycles 5..8, done 9
  task automatic test_latency3();
    logic [2:0] c3;
    logic [8:0] x3;
    logic [7:0] y3;
    rom_mode = 0;
    c3 = bus3.colour; x3 = bus3.x; y3 = bus3.y;
    bus3.x0 = 9'd5; bus3.y0 = 8'd6; bus3.width = 8'd2; bus3.height = 8'd2;
    bus3.base_addr = 14'd8; bus3.start = 1'b1;
    @(posedge clk); #1;
    bus3.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      logic ep;
      if (c <= 4) begin
        checks++;
        if (bus3.rom_addr !== 14'(7 + c)) begin
          errors++;
          $display("FAIL l3 rom_addr cyc %0d got %0d exp %0d", c, bus3.rom_addr, 7 + c);
        end
      end
      ep = (c >= 5 && c <= 8) && !(TR && c == 5);
      if (c >= 5 && c <= 8 && ep) begin
        x3 = 9'(5 + (c - 5) % 2); y3 = 8'(6 + (c - 5) / 2); c3 = 3'(c - 5);
      end
      checks++;
      if ({bus3.plot, bus3.x, bus3.y, bus3.colour} !== {ep, x3, y3, c3}) begin
        errors++;
        $display("FAIL l3 pixel cyc %0d got p%0b %0d,%0d,%0d exp p%0b %0d,%0d,%0d", c,
                 bus3.plot, bus3.x, bus3.y, bus3.colour, ep, x3, y3, c3);
      end
      checks++;
      if ({bus3.busy, bus3.done} !== {(c <= 8), (c == 9)}) begin
        errors++;
        $display("FAIL l3 busy/done cyc %0d got %0b%0b exp %0b%0b", c,
                 bus3.busy, bus3.done, (c <= 8), (c == 9));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    rom_mode = 0;
    bus1.x0 = 9'd0; bus1.y0 = 8'd0; bus1.width = 8'd8; bus1.height = 8'd8;
    bus1.base_addr = 14'd200; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus1.plot, bus1.busy, bus1.rom_addr} !== {2'b11, 14'd203}) begin
      errors++;
      $display("FAIL rst_mid pre got p%0b b%0b addr %0d exp p1 b1 addr 203",
               bus1.plot, bus1.busy, bus1.rom_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus1.plot, bus1.busy, bus1.done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid async got p%0b b%0b d%0b exp 000", bus1.plot, bus1.busy, bus1.done);
    end
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b0;
    ex = '0; ey = '0; ec = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus1.plot, bus1.busy, bus1.done} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid after cyc %0d got p%0b b%0b d%0b exp 000", c,
                 bus1.plot, bus1.busy, bus1.done);
      end
    end
    run_draw(2, 2, 3, 4, 200, 1'b0, "rst_fresh");
  endtask

  initial begin
    reset = 1'b1;
    bus1.start = 1'b0; bus1.x0 = '0; bus1.y0 = '0; bus1.width = '0;
    bus1.height = '0; bus1.base_addr = '0;
    bus3.start = 1'b0; bus3.x0 = '0; bus3.y0 = '0; bus3.width = '0;
    bus3.height = '0; bus3.base_addr = '0;
    ex = '0; ey = '0; ec = '0;
    test_reset();
    test_basic();
    test_zero();
    test_clip();
    test_transparency();
    test_ignore_start();
    test_latency3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

- Parametrised rectangle blitter: copies a W×H sprite from a synchronous colour ROM into the VGA adapter's frame buffer at a runtime origin.
- Emits one pixel per clock as a `rom_addr` stream plus aligned `x`/`y`/`colour`/`plot`.
- Compensates for a configurable ROM read latency and clips pixels that fall off-screen.
- Sits between the top-level animation sequencer (start/done handshake) and `vga_adapter`. Replaces the fixed-rectangle draw datapath.

## Interface
Parameters:
- `X_W`, 9, x coordinate width
- `Y_W`, 8, y coordinate width
- `ADDR_W`, 14, ROM address width
- `COLOUR_W`, 3, colour width
- `DIM_W`, 8, width/height field width
- `SCREEN_W`, 320, visible columns
- `SCREEN_H`, 240, visible rows
- `ROM_LATENCY`, 1, cycles from `rom_addr` to valid `rom_q` (≥1)
- `TRANSPARENT_COLOUR`, 3'b000, key colour (used only with macro)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: one-cycle request; sampled only in IDLE
- `x0` in X_W, `y0` in Y_W: sprite origin, latched on accepted start
- `width` in DIM_W, `height` in DIM_W: sprite size, latched on accepted start
- `base_addr` in ADDR_W: ROM address of sprite pixel (0,0), latched
- `rom_addr` out ADDR_W: ROM read address
- `rom_q` in COLOUR_W: ROM data
- `x` out X_W, `y` out Y_W, `colour` out COLOUR_W, `plot` out 1: to `vga_adapter`
- `busy` out 1: high from the cycle after an accepted start through the last pixel output cycle
- `done` out 1: one-cycle completion pulse

## Operation
- Reset values: state IDLE; `rom_addr`, `x`, `y`, `colour` = 0; `plot`, `busy`, `done` = 0; pipeline valid bits cleared.
- States:
  - IDLE: `start` → SCAN if width≠0 and height≠0, else → DONE.
  - SCAN: issue one address per cycle, row-major (col 0..W-1, then row+1). After address W·H−1 → DRAIN.
  - DRAIN: ROM_LATENCY+1 cycles flushing the pipeline → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `rom_addr` = base_addr + row·W + col, modulo 2^ADDR_W. The adder is an incrementing counter, not a multiplier.
- Screen coordinate sx = x0+col and sy = y0+row are computed at X_W+1 / Y_W+1 bits.
- A pixel is plotted only if sx < SCREEN_W and sy < SCREEN_H. Clipped pixels still consume their cycle and assert `plot`=0, so timing is independent of clipping.
- `x`/`y` carry the truncated sx/sy only when `plot`=1; otherwise they hold their previous values.
- Delay line depth ROM_LATENCY carries sx, sy and the in-bounds flag, aligned with `rom_q`.
- `start` while not IDLE is ignored. Latched parameters do not change mid-draw.
- `reset` mid-draw: immediate return to IDLE; `plot`/`done`/`busy` drop asynchronously; no further pixels emitted.

## Timing
- Accepted start at edge 0: `busy`=1 and first `rom_addr` valid in cycle 1.
- Pixel k (k=0..W·H−1) address is on `rom_addr` in cycle 1+k, and `rom_q` is valid in cycle 1+k+L, where L = ROM_LATENCY.
- Registered `x`/`y`/`colour`/`plot` for pixel k are valid in cycle 2+k+L.
- Last pixel output is in cycle 1+W·H+L. `done` is in cycle 2+W·H+L, when `busy`=0. A new start is accepted from the cycle after `done`.
- Zero-size request: `done` in cycle 1; no `plot`; `busy` stays 0.
- Throughput: 1 pixel/cycle. Total cycles start→done = W·H+L+2.

## Configuration
- `SPRITE_BLITTER_TRANSPARENCY_EN`:
  - Defined: a pixel whose `rom_q` equals TRANSPARENT_COLOUR is suppressed (`plot`=0, cycle still consumed). The comparison is done at the output register stage.
  - Undefined: every in-bounds pixel is plotted regardless of colour; the TRANSPARENT_COLOUR parameter is unused.

## Test plan
- 4×2 sprite, x0=10, y0=20, base=100, L=1 (ROM returns addr[2:0]). Expect:
  - `rom_addr` 100..107 in cycles 1..8
  - `plot` cycles 3..10 with (x,y) = (10..13,20),(10..13,21) and colour = 4,5,6,7,0,1,2,3
  - `done` in cycle 11
- width=0, height=5 → `done` in cycle 1, no `plot`, `busy` never high. Repeat with L=3: `done` still in cycle 1.
- 4×1 at x0=318, y0=239 → `plot` only for x=318,319. `done` still at cycle W·H+L+2=7.
- With `SPRITE_BLITTER_TRANSPARENCY_EN`, ROM returns 0 at odd addresses → `plot` is low on every second pixel, and `done` timing is unchanged. Without the macro, all pixels plot.
- `start` pulsed again mid-draw with different x0 → ignored; the original sprite completes unchanged.
- `reset` asserted during pixel 3 of an 8×8 draw → `plot`/`busy` drop immediately, no `done`. A fresh start after release draws from pixel 0 at base_addr.
